// File: rtl/alu_seq_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_n_if
//  Brief    : Request/response bundle for the sequential W-bit ALU.
//             Master issues op/a/b and takes results; slave is the ALU.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_seq_n_if #(
    parameter int W = 8
) ();
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   res;
    logic [W-1:0]   res_hi;
    logic           flag_z;
    logic           flag_c;
    logic           flag_v;
    logic           flag_dz;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res, res_hi, flag_z, flag_c, flag_v, flag_dz
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res, res_hi, flag_z, flag_c, flag_v, flag_dz
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_n.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_n
//  Brief    : Handshaked W-bit ALU, 16 opcodes. Single-cycle ops register
//             their result directly; MUL (shift-add) and DIV (restoring)
//             iterate one bit per clock for W clocks. One op in flight.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_n #(
    parameter int W   = 8,
    parameter int SHW = $clog2(W)
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_n_if.slave  bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_mul  = 4'd2;
    localparam logic [3:0] c_op_div  = 4'd3;
    localparam logic [3:0] c_op_and  = 4'd4;
    localparam logic [3:0] c_op_or   = 4'd5;
    localparam logic [3:0] c_op_xor  = 4'd6;
    localparam logic [3:0] c_op_not  = 4'd7;
    localparam logic [3:0] c_op_pa   = 4'd8;
    localparam logic [3:0] c_op_pb   = 4'd9;
    localparam logic [3:0] c_op_sll  = 4'd10;
    localparam logic [3:0] c_op_srl  = 4'd11;
    localparam logic [3:0] c_op_sra  = 4'd12;
    localparam logic [3:0] c_op_inc4 = 4'd13;
    localparam logic [3:0] c_op_dec4 = 4'd14;
    localparam logic [3:0] c_op_pop  = 4'd15;

    localparam logic [W-1:0]   c_w_val   = W'(W);
    localparam logic [W-1:0]   c_four    = W'(4);
    localparam logic [SHW-1:0] c_last_it = SHW'(W - 1);

    logic [1:0]     r_state;
    logic [SHW-1:0] r_count;
    logic           r_is_div;
    logic [W-1:0]   r_hi;      // MUL: partial product high / DIV: partial remainder
    logic [W-1:0]   r_lo;      // MUL: multiplier shifting out / DIV: dividend -> quotient
    logic [W-1:0]   r_opnd;    // MUL: multiplicand / DIV: divisor
    logic [W-1:0]   r_res;
    logic [W-1:0]   r_res_hi;
    logic           r_z;
    logic           r_c;
    logic           r_v;
    logic           r_dz;

    logic           w_accept;
    logic           w_iter_op;
    logic [W-1:0]   w_rhs;
    logic [W:0]     w_wide;
    logic           w_sh_big;
    logic [SHW-1:0] w_sh;
    logic signed [W-1:0] w_sra;
    logic [W-1:0]   w_pop;
    logic [W-1:0]   w_res;
    logic [W-1:0]   w_hi;
    logic           w_c;
    logic           w_v;
    logic           w_dz;
    logic [W:0]     w_mul_sum;
    logic [W:0]     w_div_shift;
    logic [W:0]     w_div_trial;
    logic [W-1:0]   w_it_hi;
    logic [W-1:0]   w_it_lo;

    assign w_accept  = bus.in_valid && (r_state == c_st_idle);
    // Divide by zero never iterates; it resolves in one cycle like the logic ops
    assign w_iter_op = (bus.op == c_op_mul) || ((bus.op == c_op_div) && (bus.b != '0));

    // +4/-4 share the add/sub datapath with a constant right-hand side
    assign w_rhs    = ((bus.op == c_op_inc4) || (bus.op == c_op_dec4)) ? c_four : bus.b;
    // Any shift amount of W or more saturates rather than wrapping
    assign w_sh_big = (bus.b >= c_w_val);
    assign w_sh     = bus.b[SHW-1:0];
    assign w_sra    = $signed(bus.a) >>> w_sh;

    // Single-cycle result and flags, evaluated on the presented operands
    always_comb begin
        w_wide = '0;
        w_res  = '0;
        w_hi   = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_dz   = 1'b0;
        w_pop  = '0;
        for (int i = 0; i < W; i++) begin
            w_pop = w_pop + W'(bus.a[i]);
        end
        case (bus.op)
            c_op_add, c_op_inc4: begin
                w_wide = {1'b0, bus.a} + {1'b0, w_rhs};
                w_res  = w_wide[W-1:0];
                w_c    = w_wide[W];
                w_v    = (bus.a[W-1] == w_rhs[W-1]) && (w_res[W-1] != bus.a[W-1]);
            end
            c_op_sub, c_op_dec4: begin
                w_wide = {1'b0, bus.a} - {1'b0, w_rhs};
                w_res  = w_wide[W-1:0];
                w_c    = w_wide[W];
                w_v    = (bus.a[W-1] != w_rhs[W-1]) && (w_res[W-1] != bus.a[W-1]);
            end
            c_op_mul: w_res = '0;
            c_op_div: begin
                w_res = '1;
                w_hi  = bus.a;
                w_dz  = 1'b1;
            end
            c_op_and: w_res = bus.a & bus.b;
            c_op_or:  w_res = bus.a | bus.b;
            c_op_xor: w_res = bus.a ^ bus.b;
            c_op_not: w_res = ~bus.a;
            c_op_pa:  w_res = bus.a;
            c_op_pb:  w_res = bus.b;
            c_op_sll: w_res = w_sh_big ? '0 : (bus.a << w_sh);
            c_op_srl: w_res = w_sh_big ? '0 : (bus.a >> w_sh);
            c_op_sra: w_res = w_sh_big ? {W{bus.a[W-1]}} : w_sra;
            c_op_pop: w_res = w_pop;
            default:  w_res = '0;
        endcase
    end

    // One multiply or divide step: shift-add product or restoring quotient bit
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_div_shift = {r_hi, r_lo[W-1]};
        w_div_trial = w_div_shift - {1'b0, r_opnd};
        if (r_is_div) begin
            if (!w_div_trial[W]) begin
                w_it_hi = w_div_trial[W-1:0];
                w_it_lo = {r_lo[W-2:0], 1'b1};
            end else begin
                w_it_hi = w_div_shift[W-1:0];
                w_it_lo = {r_lo[W-2:0], 1'b0};
            end
        end else begin
            w_it_hi = w_mul_sum[W:1];
            w_it_lo = {w_mul_sum[0], r_lo[W-1:1]};
        end
    end

    // Control FSM, iteration registers and held result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_res    <= '0;
            r_res_hi <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (w_iter_op) begin
                            r_state  <= c_st_busy;
                            r_count  <= '0;
                            r_is_div <= (bus.op == c_op_div);
                            r_hi     <= '0;
                            r_lo     <= (bus.op == c_op_div) ? bus.a : bus.b;
                            r_opnd   <= (bus.op == c_op_div) ? bus.b : bus.a;
                        end else begin
                            r_state  <= c_st_done;
                            r_res    <= w_res;
                            r_res_hi <= w_hi;
                            r_z      <= (w_res == '0);
                            r_c      <= w_c;
                            r_v      <= w_v;
                            r_dz     <= w_dz;
                        end
                    end
                end
                c_st_busy: begin
                    r_hi    <= w_it_hi;
                    r_lo    <= w_it_lo;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last_it) begin
                        // Low word is product-low or quotient; high is product-high or remainder
                        r_state  <= c_st_done;
                        r_count  <= '0;
                        r_res    <= w_it_lo;
                        r_res_hi <= w_it_hi;
                        r_z      <= (w_it_lo == '0);
                        r_c      <= 1'b0;
                        r_v      <= !r_is_div && (w_it_hi != '0);
                        r_dz     <= 1'b0;
                    end
                end
                c_st_done: begin
                    if (bus.out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_st_idle);
    assign bus.out_valid = (r_state == c_st_done);
    assign bus.res       = r_res;
    assign bus.res_hi    = r_res_hi;
    assign bus.flag_z    = r_z;
    assign bus.flag_c    = r_c;
    assign bus.flag_v    = r_v;
    assign bus.flag_dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_n
//  Brief    : Self-checking bench for alu_seq_n (W=8 random stream against a
//             behavioural model, plus directed W=16 MUL/DIV/ADD checks).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_n;

    localparam int TW   = 8;
    localparam int TMOD = 1 << TW;

    typedef struct packed {
        logic [TW-1:0] res;
        logic [TW-1:0] hi;
        logic          z;
        logic          c;
        logic          v;
        logic          dz;
    } exp_t;

    typedef struct packed {
        logic [3:0]    op;
        logic [TW-1:0] a;
        logic [TW-1:0] b;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_seq_n_if #(.W(TW)) bus ();
    alu_seq_n_if #(.W(16)) bus16 ();

    alu_seq_n #(.W(TW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    alu_seq_n #(.W(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs computed from the opcode definitions with integer arithmetic
    function automatic exp_t ref_model(input logic [3:0] op, input logic [TW-1:0] a, input logic [TW-1:0] b);
        exp_t e;
        int ua, ub, sa, sb, r, hi, half;
        e    = '0;
        r    = 0;
        hi   = 0;
        half = TMOD / 2;
        ua   = int'(a);
        ub   = int'(b);
        if (op == 4'd13 || op == 4'd14) ub = 4;
        sa   = (ua >= half) ? ua - TMOD : ua;
        sb   = (ub >= half) ? ub - TMOD : ub;
        case (int'(op))
            0, 13: begin
                r    = ua + ub;
                e.c  = (r >= TMOD);
                e.v  = ((sa + sb) > half - 1) || ((sa + sb) < -half);
            end
            1, 14: begin
                r    = ua - ub;
                e.c  = (ua < ub);
                e.v  = ((sa - sb) > half - 1) || ((sa - sb) < -half);
            end
            2: begin
                r    = ua * ub;
                hi   = r / TMOD;
                e.v  = (hi != 0);
            end
            3: begin
                if (ub == 0) begin
                    r    = TMOD - 1;
                    hi   = ua;
                    e.dz = 1'b1;
                end else begin
                    r    = ua / ub;
                    hi   = ua % ub;
                end
            end
            4:  r = ua & ub;
            5:  r = ua | ub;
            6:  r = ua ^ ub;
            7:  r = TMOD - 1 - ua;
            8:  r = ua;
            9:  r = ub;
            10: r = (ub >= TW) ? 0 : (ua << ub);
            11: r = (ub >= TW) ? 0 : (ua >> ub);
            12: r = (ub >= TW) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
            default: begin
                for (int i = 0; i < TW; i++) r += int'(a[i]);
            end
        endcase
        r     = ((r % TMOD) + TMOD) % TMOD;
        e.res = TW'(r);
        e.hi  = TW'(hi);
        e.z   = (r == 0);
        return e;
    endfunction

    function automatic logic is_iter(input logic [3:0] op, input logic [TW-1:0] b);
        return (op == 4'd2) || (op == 4'd3 && b != '0);
    endfunction

    // Transaction-level model: idle, counting down the latency, or presenting
    logic m_idle;
    logic m_valid;
    int   m_wait;
    exp_t m_exp;

    // Advance the model on each clock using the bench-driven handshake inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_wait  <= 0;
        end else if (m_valid) begin
            if (bus.out_ready) begin
                m_valid <= 1'b0;
                m_idle  <= 1'b1;
            end
        end else if (!m_idle) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_valid <= 1'b1;
        end else if (bus.in_valid) begin
            m_exp   <= ref_model(bus.op, bus.a, bus.b);
            m_wait  <= is_iter(bus.op, bus.b) ? TW : 0;
            m_idle  <= 1'b0;
            m_valid <= !is_iter(bus.op, bus.b);
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        chk("in_ready", 32'(bus.in_ready), 32'(m_idle));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("res", 32'(bus.res), 32'(m_exp.res));
            chk("res_hi", 32'(bus.res_hi), 32'(m_exp.hi));
            chk("flag_z", 32'(bus.flag_z), 32'(m_exp.z));
            chk("flag_c", 32'(bus.flag_c), 32'(m_exp.c));
            chk("flag_v", 32'(bus.flag_v), 32'(m_exp.v));
            chk("flag_dz", 32'(bus.flag_dz), 32'(m_exp.dz));
        end
    end

    task automatic run16(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic [15:0] eh, input logic ev, input int elat);
        int lat;
        @(posedge clk); #1;
        bus16.in_valid = 1'b1;
        bus16.op       = op;
        bus16.a        = a;
        bus16.b        = b;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 1;
        while (!bus16.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(elat));
        chk({nm, "_res"}, 32'(bus16.res), 32'(er));
        chk({nm, "_hi"}, 32'(bus16.res_hi), 32'(eh));
        chk({nm, "_v"}, 32'(bus16.flag_v), 32'(ev));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        req_t q[$];
        req_t r;
        logic acc;
        int   cyc;

        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.op          = '0;
        bus.a           = '0;
        bus.b           = '0;
        bus.out_ready   = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.op        = '0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_res", 32'(bus.res), 0);
        chk("rst_res_hi", 32'(bus.res_hi), 0);
        chk("rst_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_dz}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(bus.in_ready), 1);

        // Hand-computed values that pin the reference model
        e = ref_model(4'd0, 8'hF0, 8'h20);
        chk("pin_add_res", 32'(e.res), 32'h10);
        chk("pin_add_cvz", 32'({e.c, e.v, e.z}), 32'b100);
        e = ref_model(4'd1, 8'h80, 8'h01);
        chk("pin_sub_res", 32'(e.res), 32'h7F);
        chk("pin_sub_vc", 32'({e.v, e.c}), 32'b10);
        e = ref_model(4'd1, 8'h05, 8'h05);
        chk("pin_sub_z", 32'({e.res, e.z}), 32'h001);
        e = ref_model(4'd2, 8'hFF, 8'hFF);
        chk("pin_mul", 32'({e.res, e.hi, e.v}), {15'd0, 8'h01, 8'hFE, 1'b1});
        e = ref_model(4'd3, 8'd200, 8'd7);
        chk("pin_div", 32'({e.res, e.hi}), {16'd0, 8'd28, 8'd4});
        e = ref_model(4'd3, 8'h37, 8'h00);
        chk("pin_div0", 32'({e.res, e.hi, e.dz}), {15'd0, 8'hFF, 8'h37, 1'b1});
        e = ref_model(4'd12, 8'h90, 8'd9);
        chk("pin_sra", 32'(e.res), 32'hFF);
        e = ref_model(4'd10, 8'h01, 8'd8);
        chk("pin_sll", 32'(e.res), 32'h00);
        e = ref_model(4'd15, 8'hB7, 8'h00);
        chk("pin_pop", 32'(e.res), 32'd6);
        e = ref_model(4'd14, 8'h02, 8'h00);
        chk("pin_dec4", 32'({e.res, e.c}), {23'd0, 8'hFE, 1'b1});

        // Directed vectors first (ADD result is held under backpressure), then random
        q.push_back('{4'd0,  8'hF0, 8'h20});
        q.push_back('{4'd1,  8'h80, 8'h01});
        q.push_back('{4'd1,  8'h05, 8'h05});
        q.push_back('{4'd2,  8'hFF, 8'hFF});
        q.push_back('{4'd3,  8'd200, 8'd7});
        q.push_back('{4'd3,  8'h37, 8'h00});
        q.push_back('{4'd12, 8'h90, 8'd9});
        q.push_back('{4'd10, 8'h01, 8'd8});
        q.push_back('{4'd15, 8'hB7, 8'h00});
        q.push_back('{4'd14, 8'h02, 8'h00});
        for (int i = 0; i < 200; i++) begin
            r.op = 4'($urandom);
            r.a  = 8'($urandom);
            r.b  = 8'($urandom);
            if (r.op >= 4'd10 && r.op <= 4'd12 && $urandom_range(0, 1) == 1) r.b = 8'($urandom_range(0, 11));
            if (r.op == 4'd3 && $urandom_range(0, 4) == 0) r.b = '0;
            if (r.op <= 4'd1 && $urandom_range(0, 3) == 0) r.a = 8'h80 ^ 8'($urandom_range(0, 1));
            q.push_back(r);
        end

        cyc = 0;
        while ((q.size() > 0 || bus.in_valid || !m_idle) && cyc < 8000) begin
            @(negedge clk);
            acc = bus.in_valid && m_idle;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                // Operands were captured; disturb them to prove they are not re-read
                bus.in_valid = 1'b0;
                bus.op       = 4'($urandom);
                bus.a        = 8'($urandom);
                bus.b        = 8'($urandom);
            end
            if (!bus.in_valid && q.size() > 0 && $urandom_range(0, 3) != 0) begin
                r            = q.pop_front();
                bus.in_valid = 1'b1;
                bus.op       = r.op;
                bus.a        = r.a;
                bus.b        = r.b;
            end
            bus.out_ready = (cyc < 14) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        chk("stream_drained", 32'(q.size()), 0);

        // Reset in the middle of a MUL aborts it with no result
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.op       = 4'd2;
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("abort_busy", 32'(bus.in_ready), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_res", 32'(bus.res), 0);
        chk("abort_res_hi", 32'(bus.res_hi), 0);
        chk("abort_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_dz}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < TW + 4; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(bus.out_valid), 0);
        end

        // W=16 instance
        run16("w16_mul", 4'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 17);
        run16("w16_div", 4'd3, 16'd50000, 16'd7, 16'd7142, 16'd6, 1'b0, 17);
        run16("w16_add", 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
